// File: rtl/spi_adc_reader.sv
// -----------------------------------------------------------------------------
// spi_adc_reader
//
// SPI master read controller for a serial ADC (mode 0, MSB first). One
// request on strr_i frames a complete conversion read: CS setup, DATA_WIDTH
// SCK periods, and a CS high hold. The received word is then presented on
// data_o together with a single-cycle dv_o pulse.
//
// The CS/SCK timing matches the DAC write controller, so both can share one
// board-level SPI bus.
//
// Parameters
//   DATA_WIDTH : bits per frame (>= 1)
//   CLK_DIV    : clk_i cycles per SCK half-period, and the length of the
//                CS setup and CS hold phases (>= 1)
//
// Ports
//   clk_i   in   system clock, rising edge
//   rst_i   in   synchronous reset, active low
//   strr_i  in   start-read request; only looked at while idle
//   miso_i  in   serial data from the ADC
//   cs_o    out  chip select, active low
//   sck_o   out  serial clock, idles low
//   data_o  out  last captured word; MSB is the first bit received
//   dv_o    out  one-cycle pulse when data_o is updated
//   eor_o   out  high only while idle
// -----------------------------------------------------------------------------
module spi_adc_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  strr_i,
    input  logic                  miso_i,
    output logic                  cs_o,
    output logic                  sck_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  dv_o,
    output logic                  eor_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_HIGH   = 3'd2,
        S_LOW    = 3'd3,
        S_CSHOLD = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DIV_W-1:0]      r_div;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_dv;

    logic                  w_tick;
    logic                  w_cs;
    logic                  w_sck;
    logic                  w_eor;
    logic                  w_start;
    logic                  w_sample;
    logic                  w_done;

    // Last cycle of the current phase.
    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode. The outputs depend on r_state only.
    always_comb begin
        w_next   = r_state;
        w_cs     = 1'b1;
        w_sck    = 1'b0;
        w_eor    = 1'b0;
        w_start  = 1'b0;
        w_sample = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_eor = 1'b1;
                if (strr_i) begin
                    w_start = 1'b1;
                    w_next  = S_SETUP;
                end
            end
            S_SETUP: begin
                w_cs = 1'b0;
                if (w_tick) begin
                    w_next = S_HIGH;
                end
            end
            S_HIGH: begin
                w_cs  = 1'b0;
                w_sck = 1'b1;
                // ADC updates MISO on the falling edge, so the last cycle of
                // the high phase sees the most settled data.
                if (w_tick) begin
                    w_sample = 1'b1;
                    w_next   = S_LOW;
                end
            end
            S_LOW: begin
                w_cs = 1'b0;
                if (w_tick) begin
                    w_next = (r_bit_cnt == CNT_W'(DATA_WIDTH)) ? S_CSHOLD : S_HIGH;
                end
            end
            S_CSHOLD: begin
                if (w_tick) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_eor  = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_dv      <= 1'b0;
        end else begin
            // Divider restarts at each phase boundary and rests while idle.
            if (r_state == S_IDLE || w_next != r_state) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            if (w_start) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_shift   <= (r_shift << 1) | DATA_WIDTH'(miso_i);
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            r_dv <= w_done;
            if (w_done) begin
                r_data <= r_shift;
            end
        end
    end

    assign cs_o   = w_cs;
    assign sck_o  = w_sck;
    assign eor_o  = w_eor;
    assign data_o = r_data;
    assign dv_o   = r_dv;

endmodule

// File: tb/tb_spi_adc_reader.sv
module tb_spi_adc_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- default instance: 16 bits, CLK_DIV=4 ----------------
    logic        m_rst, m_strr, m_miso, m_cs, m_sck, m_dv, m_eor;
    logic [15:0] m_data;

    spi_adc_reader #(.DATA_WIDTH(16), .CLK_DIV(4)) dut (
        .clk_i (clk),
        .rst_i (m_rst),
        .strr_i(m_strr),
        .miso_i(m_miso),
        .cs_o  (m_cs),
        .sck_o (m_sck),
        .data_o(m_data),
        .dv_o  (m_dv),
        .eor_o (m_eor)
    );

    // ADC model: loads the next word when CS falls, shifts on SCK falling.
    logic [15:0] m_adc_sr = 16'h0;
    logic [15:0] m_q[$];
    int          m_sck_rises = 0;
    always @(negedge m_cs) begin
        if (m_q.size() > 0) m_adc_sr = m_q.pop_front();
        else                m_adc_sr = 16'h0;
    end
    always @(negedge m_sck) m_adc_sr = m_adc_sr << 1;
    always @(posedge m_sck) m_sck_rises++;
    assign m_miso = m_adc_sr[15];

    // ---------------- edge instance: 8 bits, CLK_DIV=1 ----------------
    logic       e_rst, e_strr, e_miso, e_cs, e_sck, e_dv, e_eor;
    logic [7:0] e_data;

    spi_adc_reader #(.DATA_WIDTH(8), .CLK_DIV(1)) dut_e (
        .clk_i (clk),
        .rst_i (e_rst),
        .strr_i(e_strr),
        .miso_i(e_miso),
        .cs_o  (e_cs),
        .sck_o (e_sck),
        .data_o(e_data),
        .dv_o  (e_dv),
        .eor_o (e_eor)
    );

    logic [7:0] e_adc_sr = 8'h0;
    logic [7:0] e_q[$];
    int         e_sck_rises = 0;
    always @(negedge e_cs) begin
        if (e_q.size() > 0) e_adc_sr = e_q.pop_front();
        else                e_adc_sr = 8'h0;
    end
    always @(negedge e_sck) e_adc_sr = e_adc_sr << 1;
    always @(posedge e_sck) e_sck_rises++;
    assign e_miso = e_adc_sr[7];

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-frame observations on the default instance.
    int          dv_k[2];
    logic [15:0] dv_d[2];
    int          dv_cnt, cs_lo, cs_hi_early, sck0;

    // Starts a frame at k=0 (edge E0) and observes the state after E0+k for
    // k = 0..last. busy_at pulses strr_i into edge E0+busy_at, drop_at
    // releases a held strr_i before edge E0+drop_at.
    task automatic run(input int last, input int busy_at, input int drop_at, input bit hold);
        dv_cnt      = 0;
        cs_lo       = 0;
        cs_hi_early = 0;
        dv_k[0] = -1; dv_k[1] = -1;
        dv_d[0] = '0; dv_d[1] = '0;
        sck0 = m_sck_rises;
        for (int k = 0; k <= last; k++) begin
            if (k == 0 || k == busy_at) m_strr = 1'b1;
            if (k == drop_at)           m_strr = 1'b0;
            step();
            if ((k == 0 && !hold) || k == busy_at) m_strr = 1'b0;
            if (!m_cs) cs_lo++;
            if (m_cs && k < 200) cs_hi_early++;
            if (m_dv) begin
                chk("eor_with_dv", m_eor, 1'b1);
                if (dv_cnt < 2) begin
                    dv_k[dv_cnt] = k;
                    dv_d[dv_cnt] = m_data;
                end
                dv_cnt++;
            end
        end
    endtask

    typedef struct {
        logic       rst;
        logic       strr;
        logic       cs;
        logic       sck;
        logic       eor;
        logic       dv;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[24];

    initial begin
        int e_sck0;

        m_rst = 1'b0; m_strr = 1'b0;
        e_rst = 1'b0; e_strr = 1'b0;

        // Edge-instance cycle table. Index 3 is edge E0; entry 3+k is the
        // state after E0+k. With CLK_DIV=1 every phase lasts one cycle.
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int k = 1; k <= 16; k++)
            tbl[3+k] = '{1'b1, 1'b0, 1'b0, logic'(k % 2), 1'b0, 1'b0, 8'h00};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80};
        tbl[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80};
        tbl[23] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80};

        // Reset with strr_i high on the default instance.
        m_strr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_cs",   m_cs,   1'b1);
            chk("rst_sck",  m_sck,  1'b0);
            chk("rst_data", m_data, 16'h0);
            chk("rst_dv",   m_dv,   1'b0);
            chk("rst_eor",  m_eor,  1'b1);
        end
        m_strr = 1'b0;
        m_rst  = 1'b1;
        step();
        chk("idle_eor", m_eor, 1'b1);

        // Edge parameters: CLK_DIV=1, DATA_WIDTH=8, pattern 0x80.
        e_q.push_back(8'h80);
        e_sck0 = e_sck_rises;
        for (int i = 0; i < 24; i++) begin
            e_rst  = tbl[i].rst;
            e_strr = tbl[i].strr;
            step();
            chk($sformatf("edge_cs[%0d]", i),   e_cs,   tbl[i].cs);
            chk($sformatf("edge_sck[%0d]", i),  e_sck,  tbl[i].sck);
            chk($sformatf("edge_eor[%0d]", i),  e_eor,  tbl[i].eor);
            chk($sformatf("edge_dv[%0d]", i),   e_dv,   tbl[i].dv);
            chk($sformatf("edge_data[%0d]", i), e_data, tbl[i].data);
        end
        chk("edge_sck_count", e_sck_rises - e_sck0, 8);

        // Single frame 0xA5C3.
        m_q.push_back(16'hA5C3);
        run(200, -1, -1, 1'b0);
        chk("single_dv_count", dv_cnt, 1);
        chk("single_dv_at",    dv_k[0], 136);
        chk("single_data",     dv_d[0], 16'hA5C3);
        chk("single_sck",      m_sck_rises - sck0, 16);
        chk("single_cs_low",   cs_lo, 132);
        chk("single_hold",     m_data, 16'hA5C3);

        // Busy strobe at E0+50 is ignored.
        m_q.push_back(16'h3C96);
        run(200, 50, -1, 1'b0);
        chk("busy_dv_count", dv_cnt, 1);
        chk("busy_dv_at",    dv_k[0], 136);
        chk("busy_data",     dv_d[0], 16'h3C96);
        chk("busy_sck",      m_sck_rises - sck0, 16);

        // Back-to-back with strr_i held high.
        m_q.push_back(16'h0001);
        m_q.push_back(16'hFFFF);
        run(300, -1, 274, 1'b1);
        chk("b2b_dv_count", dv_cnt, 2);
        chk("b2b_dv0_at",   dv_k[0], 136);
        chk("b2b_dv1_at",   dv_k[1], 273);
        chk("b2b_data0",    dv_d[0], 16'h0001);
        chk("b2b_data1",    dv_d[1], 16'hFFFF);
        chk("b2b_cs_gap",   cs_hi_early, 5);
        chk("b2b_sck",      m_sck_rises - sck0, 32);
        chk("b2b_idle",     m_eor, 1'b1);

        // Reset at E0+70 aborts the frame.
        m_q.push_back(16'h1234);
        run(69, -1, -1, 1'b0);
        chk("abort_in_frame", m_cs, 1'b0);
        m_rst = 1'b0;
        step();
        chk("abort_cs",   m_cs,   1'b1);
        chk("abort_sck",  m_sck,  1'b0);
        chk("abort_data", m_data, 16'h0);
        chk("abort_dv",   m_dv,   1'b0);
        chk("abort_eor",  m_eor,  1'b1);
        m_rst = 1'b1;
        step();
        chk("abort_stay_idle", m_cs, 1'b1);
        chk("abort_no_dv",     m_dv, 1'b0);

        m_q.push_back(16'h5A3C);
        run(140, -1, -1, 1'b0);
        chk("after_abort_dv_count", dv_cnt, 1);
        chk("after_abort_dv_at",    dv_k[0], 136);
        chk("after_abort_data",     dv_d[0], 16'h5A3C);
        chk("after_abort_sck",      m_sck_rises - sck0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
